lsu_mem_ctrl: RTL and testbench

Load/store unit that consumes the data address computed at the register-file stage. It runs a multi-cycle request/acknowledge transaction to data memory and returns aligned, extended load data for register writeback. It stalls the core via busy until done pulses. It also flags misaligned accesses and memory timeouts.

---
 rtl/lsu_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one request/acknowledge memory transaction per start, with alignment
// checks, a request timeout, and aligned, sign- or zero-extended load data for writeback.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] daddr,
  input  logic [31:0] rv2,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [5:0] OP_LB  = 6'd19;
  localparam logic [5:0] OP_LH  = 6'd20;
  localparam logic [5:0] OP_LW  = 6'd21;
  localparam logic [5:0] OP_LBU = 6'd22;
  localparam logic [5:0] OP_LHU = 6'd23;
  localparam logic [5:0] OP_SB  = 6'd24;
  localparam logic [5:0] OP_SH  = 6'd25;
  localparam logic [5:0] OP_SW  = 6'd26;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  addr_lo;
  logic [5:0]  op_q;

  logic        is_mem;
  logic        is_load_q;
  logic        mis;
  logic [3:0]  we_n;
  logic [31:0] wd_n;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] ld_n;

  always_comb begin
    is_mem    = (op >= OP_LB) && (op <= OP_SW);
    is_load_q = (op_q >= OP_LB) && (op_q <= OP_LHU);
    mis       = 1'b0;
    we_n      = 4'b0000;
    wd_n      = 32'h0;
    case (op)
      OP_LH, OP_LHU: mis = daddr[0];
      OP_LW:         mis = |daddr[1:0];
      OP_SB: begin
        we_n = 4'b0001 << daddr[1:0];
        wd_n = {4{rv2[7:0]}};
      end
      OP_SH: begin
        mis  = daddr[0];
        we_n = daddr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{rv2[15:0]}};
      end
      OP_SW: begin
        mis  = |daddr[1:0];
        we_n = 4'b1111;
        wd_n = rv2;
      end
      default: ;
    endcase
  end

  // Byte lane selection uses the offset latched at request time, not the live daddr.
  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    half    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_n = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  ld_n = {24'h0, shifted[7:0]};
      OP_LH:   ld_n = {{16{half[15]}}, half};
      OP_LHU:  ld_n = {16'h0, half};
      default: ld_n = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'h0;
      addr_lo    <= 2'b00;
      op_q       <= 6'h0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      mem_we     <= 4'b0000;
      mem_wdata  <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ld_data    <= 32'h0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && is_mem) begin
            busy <= 1'b1;
            if (mis) begin
              state      <= S_DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_addr  <= {daddr[31:2], 2'b00};
              mem_we    <= we_n;
              mem_wdata <= wd_n;
              addr_lo   <= daddr[1:0];
              op_q      <= op;
              cnt       <= 8'h0;
            end
          end
        end
        S_REQ: begin
          // An ack on the timeout edge still completes the access normally.
          if (mem_ack) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 4'b0000;
            done    <= 1'b1;
            if (is_load_q) ld_data <= ld_n;
          end else if (cnt == TO_LAST) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 4'b0000;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: expected completions are queued at issue and
// compared when done pulses; request-side outputs are checked on the first REQ cycle.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] rv2 = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        bus_err;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_ld = 32'h0;

  lsu_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .daddr(daddr), .rv2(rv2),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .ld_data(ld_data), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack_edge: REQ edge (1 = first edge after the request appears) carrying mem_ack; 0 = never.
  task automatic run_txn(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] rd, input int ack_edge,
                         input logic [31:0] e_addr, input logic [3:0] e_we,
                         input bit chk_wd, input logic [31:0] e_wd, input int e_reqc,
                         input logic [31:0] e_ld, input bit e_mis, input bit e_berr);
    exp_t e;
    exp_t got_e;
    int   reqc;
    bit   got;
    e.ld = e_ld; e.mis = e_mis; e.berr = e_berr;
    sb_q.push_back(e);
    start = 1'b1; op = o; daddr = a; rv2 = r2;
    tick();
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    if (e_reqc > 0) begin
      chk({tag, "_addr"}, mem_addr, e_addr);
      chk({tag, "_we"}, 32'(mem_we), 32'(e_we));
      if (chk_wd) chk({tag, "_wdata"}, mem_wdata, e_wd);
    end
    reqc = 0;
    got = 1'b0;
    for (int n = 1; n <= 60 && !got; n++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (mem_req) reqc++;
        mem_ack = (n == ack_edge);
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_req_cycles"}, 32'(reqc), 32'(e_reqc));
    if (got) begin
      got_e = sb_q.pop_front();
      chk({tag, "_ld"}, ld_data, got_e.ld);
      chk({tag, "_mis"}, 32'(misaligned), 32'(got_e.mis));
      chk({tag, "_berr"}, 32'(bus_err), 32'(got_e.berr));
      chk({tag, "_req_in_done"}, 32'(mem_req), 32'd0);
      start = 1'b0;
      tick();
      chk({tag, "_done_once"}, 32'(done), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    end else begin
      start = 1'b0;
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    bit seen;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ld", ld_data, 32'h0);
    chk("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    run_txn("lw", 6'd21, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'h100, 4'b0000, 1'b0, 32'h0,
            3, 32'hDEADBEEF, 1'b0, 1'b0);
    run_txn("lb", 6'd19, 32'h103, 32'h0, 32'h80FF1234, 1, 32'h100, 4'b0000, 1'b0, 32'h0,
            1, 32'hFFFFFF80, 1'b0, 1'b0);
    run_txn("lbu", 6'd22, 32'h103, 32'h0, 32'h80FF1234, 2, 32'h100, 4'b0000, 1'b0, 32'h0,
            2, 32'h00000080, 1'b0, 1'b0);
    run_txn("lhu", 6'd23, 32'h102, 32'h0, 32'h80FF1234, 1, 32'h100, 4'b0000, 1'b0, 32'h0,
            1, 32'h000080FF, 1'b0, 1'b0);
    run_txn("lh", 6'd20, 32'h102, 32'h0, 32'h80FF1234, 1, 32'h100, 4'b0000, 1'b0, 32'h0,
            1, 32'hFFFF80FF, 1'b0, 1'b0);
    run_txn("lb1", 6'd19, 32'h101, 32'h0, 32'h80FF1234, 1, 32'h100, 4'b0000, 1'b0, 32'h0,
            1, 32'h00000012, 1'b0, 1'b0);
    last_ld = 32'h00000012;
    run_txn("sh", 6'd25, 32'h206, 32'h1234ABCD, 32'h55555555, 2, 32'h204, 4'b1100, 1'b1,
            32'hABCDABCD, 2, last_ld, 1'b0, 1'b0);
    run_txn("sb", 6'd24, 32'h201, 32'h000000EF, 32'h55555555, 1, 32'h200, 4'b0010, 1'b1,
            32'hEFEFEFEF, 1, last_ld, 1'b0, 1'b0);
    run_txn("mis", 6'd21, 32'h102, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 1'b0, 32'h0,
            0, last_ld, 1'b1, 1'b0);
    run_txn("sw_to", 6'd26, 32'h300, 32'hCAFEF00D, 32'h0, 0, 32'h300, 4'b1111, 1'b1,
            32'hCAFEF00D, 16, last_ld, 1'b0, 1'b1);
    run_txn("sw_ack16", 6'd26, 32'h304, 32'h0BADC0DE, 32'h0, 16, 32'h304, 4'b1111, 1'b1,
            32'h0BADC0DE, 16, last_ld, 1'b0, 1'b0);

    // A non-memory opcode and a stray ack while idle must both be ignored.
    start = 1'b1; op = 6'd5; daddr = 32'h100; mem_ack = 1'b1;
    tick();
    tick();
    chk("nonmem_busy", 32'(busy), 32'd0);
    chk("nonmem_done", 32'(done), 32'd0);
    chk("nonmem_req", 32'(mem_req), 32'd0);
    chk("stray_ack_ld", ld_data, last_ld);
    start = 1'b0; mem_ack = 1'b0;

    // Reset in the middle of a request.
    start = 1'b1; op = 6'd21; daddr = 32'h400;
    tick();
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rstmid_req_drop", 32'(mem_req), 32'd0);
    chk("rstmid_busy_drop", 32'(busy), 32'd0);
    chk("rstmid_ld_clr", ld_data, 32'h0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("rstmid_no_done", 32'(seen), 32'd0);
    last_ld = 32'h0;

    run_txn("lw_post", 6'd21, 32'h400, 32'h0, 32'h13579BDF, 2, 32'h400, 4'b0000, 1'b0, 32'h0,
            2, 32'h13579BDF, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
